// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM: registered state, outputs decoded from state and opcode.
// Optional macro STACK_OPS_EN enables CALL/RET/PUSH/POP; without it opcodes 12-15 are illegal.
module multicycle_control (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic [1:0] mode,
   input  logic       z,
   input  logic       n,
   input  logic       v,
   output logic       MemWriteSel,
   output logic       MemReg,
   output logic       RegSrc,
   output logic       RegWrite,
   output logic       RegWrite2,
   output logic       IRwrite,
   output logic       PCwrite,
   output logic       StackWrite,
   output logic       sign_ext,
   output logic       StackSelect,
   output logic       mem_read,
   output logic       mem_write,
   output logic       illegal,
   output logic [1:0] ALUsrcA,
   output logic [1:0] ALUsrcB,
   output logic [1:0] PCsrc,
   output logic [1:0] ALUop,
   output logic [1:0] StackALU
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_EXEC   = 4'd2,
      S_ADDR   = 4'd3,
      S_WB_ALU = 4'd4,
      S_MEM_RD = 4'd5,
      S_BRANCH = 4'd6,
      S_JUMP   = 4'd7,
      S_CALL   = 4'd8,
      S_RET    = 4'd9,
      S_PUSH   = 4'd10,
      S_POP    = 4'd11,
      S_MEM_WR = 4'd12,
      S_WB_MEM = 4'd13
   } state_t;

   localparam logic [5:0] OP_AND  = 6'd0;
   localparam logic [5:0] OP_ADD  = 6'd1;
   localparam logic [5:0] OP_SUB  = 6'd2;
   localparam logic [5:0] OP_ANDI = 6'd3;
   localparam logic [5:0] OP_ADDI = 6'd4;
   localparam logic [5:0] OP_LW   = 6'd5;
   localparam logic [5:0] OP_SW   = 6'd6;
   localparam logic [5:0] OP_BGT  = 6'd7;
   localparam logic [5:0] OP_BLT  = 6'd8;
   localparam logic [5:0] OP_BEQ  = 6'd9;
   localparam logic [5:0] OP_BNE  = 6'd10;
   localparam logic [5:0] OP_J    = 6'd11;
   localparam logic [5:0] OP_CALL = 6'd12;
   localparam logic [5:0] OP_RET  = 6'd13;
   localparam logic [5:0] OP_PUSH = 6'd14;
   localparam logic [5:0] OP_POP  = 6'd15;

   localparam logic [1:0] ALU_AND = 2'b00;
   localparam logic [1:0] ALU_ADD = 2'b01;
   localparam logic [1:0] ALU_SUB = 2'b10;

   state_t state, next_state;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_FETCH;
      else        state <= next_state;
   end

   always_comb begin
      next_state  = S_FETCH;
      MemWriteSel = 1'b0;
      MemReg      = 1'b0;
      RegWrite    = 1'b0;
      RegWrite2   = 1'b0;
      IRwrite     = 1'b0;
      PCwrite     = 1'b0;
      StackWrite  = 1'b0;
      StackSelect = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      illegal     = 1'b0;
      ALUsrcA     = '0;
      ALUsrcB     = '0;
      PCsrc       = '0;
      ALUop       = '0;
      StackALU    = '0;
      sign_ext    = (opcode != OP_ANDI);
      RegSrc      = (opcode == OP_SW) || (opcode >= OP_BGT && opcode <= OP_BNE);
`ifdef STACK_OPS_EN
      if (opcode == OP_PUSH) RegSrc = 1'b1;
`endif

      case (state)
         S_FETCH: begin
            IRwrite    = 1'b1;
            PCwrite    = 1'b1;
            ALUsrcB    = 2'b10;
            ALUop      = ALU_ADD;
            PCsrc      = 2'b01;
            next_state = S_DECODE;
         end
         S_DECODE: begin
            ALUsrcB = 2'b01;
            ALUop   = ALU_ADD;
            case (opcode)
               OP_AND, OP_ADD, OP_SUB,
               OP_ANDI, OP_ADDI:          next_state = S_EXEC;
               OP_LW, OP_SW:              next_state = S_ADDR;
               OP_BGT, OP_BLT,
               OP_BEQ, OP_BNE:            next_state = S_BRANCH;
               OP_J:                      next_state = S_JUMP;
`ifdef STACK_OPS_EN
               OP_CALL:                   next_state = S_CALL;
               OP_RET:                    next_state = S_RET;
               OP_PUSH:                   next_state = S_PUSH;
               OP_POP:                    next_state = S_POP;
`endif
               default: begin
                  illegal    = 1'b1;
                  next_state = S_FETCH;
               end
            endcase
         end
         S_EXEC: begin
            ALUsrcA = 2'b01;
            ALUsrcB = (opcode == OP_ANDI || opcode == OP_ADDI) ? 2'b01 : 2'b00;
            if (opcode == OP_AND || opcode == OP_ANDI)      ALUop = ALU_AND;
            else if (opcode == OP_SUB)                      ALUop = ALU_SUB;
            else                                            ALUop = ALU_ADD;
            next_state = S_WB_ALU;
         end
         S_WB_ALU: RegWrite = 1'b1;
         S_ADDR: begin
            ALUsrcA    = 2'b01;
            ALUsrcB    = 2'b01;
            ALUop      = ALU_ADD;
            next_state = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
         end
         S_MEM_RD: begin
            mem_read   = 1'b1;
            next_state = S_WB_MEM;
         end
         S_WB_MEM: begin
            RegWrite  = 1'b1;
            MemReg    = 1'b1;
            RegWrite2 = (opcode == OP_LW) && (mode == 2'b01);
         end
         S_MEM_WR: begin
            mem_write = 1'b1;
            RegWrite2 = (mode == 2'b01);
         end
         S_BRANCH: begin
            ALUsrcA = 2'b01;
            ALUop   = ALU_SUB;
            PCsrc   = 2'b11;
            case (opcode)
               OP_BEQ:  PCwrite = z;
               OP_BNE:  PCwrite = !z;
               OP_BGT:  PCwrite = !z && (n == v);
               OP_BLT:  PCwrite = (n != v);
               default: PCwrite = 1'b0;
            endcase
         end
         S_JUMP: PCwrite = 1'b1;
`ifdef STACK_OPS_EN
         S_CALL: begin
            mem_write   = 1'b1;
            MemWriteSel = 1'b1;
            StackALU    = 2'b01;
            StackSelect = 1'b1;
            StackWrite  = 1'b1;
            PCwrite     = 1'b1;
         end
         S_RET, S_POP: begin
            // POP shares RET's stack read and SP increment, minus the PC update
            mem_read   = 1'b1;
            StackALU   = 2'b10;
            StackWrite = 1'b1;
            ALUsrcA    = 2'b10;
            ALUsrcB    = 2'b10;
            ALUop      = ALU_ADD;
            if (state == S_RET) begin
               PCsrc   = 2'b10;
               PCwrite = 1'b1;
            end else begin
               next_state = S_WB_MEM;
            end
         end
         S_PUSH: begin
            mem_write   = 1'b1;
            StackALU    = 2'b01;
            StackSelect = 1'b1;
            StackWrite  = 1'b1;
         end
`endif
         default: next_state = S_FETCH;
      endcase

      // Enables are forced low combinationally so nothing writes while reset is held
      if (!reset) begin
         IRwrite    = 1'b0;
         PCwrite    = 1'b0;
         RegWrite   = 1'b0;
         RegWrite2  = 1'b0;
         StackWrite = 1'b0;
         mem_read   = 1'b0;
         mem_write  = 1'b0;
         illegal    = 1'b0;
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control; STACK_OPS_EN selects the stack tests.
module tb_multicycle_control;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] opcode;
   logic [1:0] mode;
   logic       z, n, v;
   logic       MemWriteSel, MemReg, RegSrc, RegWrite, RegWrite2, IRwrite, PCwrite;
   logic       StackWrite, sign_ext, StackSelect, mem_read, mem_write, illegal;
   logic [1:0] ALUsrcA, ALUsrcB, PCsrc, ALUop, StackALU;
   logic [7:0] en;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   // {IRwrite, PCwrite, RegWrite, RegWrite2, StackWrite, mem_read, mem_write, illegal}
   assign en = {IRwrite, PCwrite, RegWrite, RegWrite2, StackWrite, mem_read, mem_write, illegal};

   multicycle_control dut (
      .clk(clk), .reset(reset), .opcode(opcode), .mode(mode), .z(z), .n(n), .v(v),
      .MemWriteSel(MemWriteSel), .MemReg(MemReg), .RegSrc(RegSrc), .RegWrite(RegWrite),
      .RegWrite2(RegWrite2), .IRwrite(IRwrite), .PCwrite(PCwrite), .StackWrite(StackWrite),
      .sign_ext(sign_ext), .StackSelect(StackSelect), .mem_read(mem_read),
      .mem_write(mem_write), .illegal(illegal), .ALUsrcA(ALUsrcA), .ALUsrcB(ALUsrcB),
      .PCsrc(PCsrc), .ALUop(ALUop), .StackALU(StackALU)
   );

   task automatic test_reset;
      logic [7:0] seq [3];
      seq = '{8'hC0, 8'h00, 8'h40};
      reset = 1'b0; opcode = 6'd11; mode = 2'b00; z = 0; n = 0; v = 0;
      #3;
      n_checks++;
      if (en !== 8'h00) begin n_fail++; $display("FAIL reset_en_early got=%h exp=00", en); end
      repeat (2) @(negedge clk);
      #1;
      n_checks++;
      if (en !== 8'h00) begin n_fail++; $display("FAIL reset_en_held got=%h exp=00", en); end
      @(negedge clk);
      reset = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1;
         n_checks++;
         if (en !== seq[c]) begin n_fail++; $display("FAIL reset_j_en c=%0d got=%h exp=%h", c, en, seq[c]); end
         if (c == 0) begin
            n_checks++;
            if ({ALUsrcA, ALUsrcB, ALUop, PCsrc} !== 8'b00_10_01_01) begin
               n_fail++; $display("FAIL fetch_sel got=%b exp=00100101", {ALUsrcA, ALUsrcB, ALUop, PCsrc});
            end
         end
         if (c == 1) begin
            n_checks++;
            if ({ALUsrcA, ALUsrcB, ALUop, sign_ext} !== 7'b00_01_01_1) begin
               n_fail++; $display("FAIL decode_sel got=%b exp=0001011", {ALUsrcA, ALUsrcB, ALUop, sign_ext});
            end
         end
         if (c == 2) begin
            n_checks++;
            if (PCsrc !== 2'b00) begin n_fail++; $display("FAIL jump_pcsrc got=%b exp=00", PCsrc); end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_alu;
      logic [5:0] ops   [3];
      logic [1:0] aop   [3];
      logic [1:0] srcb  [3];
      logic       sext  [3];
      logic [7:0] seq   [4];
      ops  = '{6'd1, 6'd3, 6'd2};
      aop  = '{2'b01, 2'b00, 2'b10};
      srcb = '{2'b00, 2'b01, 2'b00};
      sext = '{1'b1, 1'b0, 1'b1};
      seq  = '{8'hC0, 8'h00, 8'h00, 8'h20};
      for (int i = 0; i < 3; i++) begin
         opcode = ops[i];
         for (int c = 0; c < 4; c++) begin
            #1;
            n_checks++;
            if (en !== seq[c]) begin n_fail++; $display("FAIL alu_en op=%0d c=%0d got=%h exp=%h", ops[i], c, en, seq[c]); end
            if (c == 1) begin
               n_checks++;
               if (sign_ext !== sext[i]) begin n_fail++; $display("FAIL sign_ext op=%0d got=%b exp=%b", ops[i], sign_ext, sext[i]); end
            end
            if (c == 2) begin
               n_checks++;
               if ({ALUsrcA, ALUsrcB, ALUop} !== {2'b01, srcb[i], aop[i]}) begin
                  n_fail++; $display("FAIL exec_sel op=%0d got=%b exp=%b", ops[i], {ALUsrcA, ALUsrcB, ALUop}, {2'b01, srcb[i], aop[i]});
               end
            end
            if (c == 3) begin
               n_checks++;
               if (MemReg !== 1'b0) begin n_fail++; $display("FAIL wb_alu_memreg got=%b exp=0", MemReg); end
            end
            @(negedge clk);
         end
      end
   endtask

   task automatic test_load_store;
      logic [7:0] lw_seq [5];
      logic [7:0] sw_seq [4];
      lw_seq = '{8'hC0, 8'h00, 8'h00, 8'h04, 8'h30};
      sw_seq = '{8'hC0, 8'h00, 8'h00, 8'h02};
      opcode = 6'd5; mode = 2'b01;
      for (int c = 0; c < 5; c++) begin
         #1;
         n_checks++;
         if (en !== lw_seq[c]) begin n_fail++; $display("FAIL lw_en c=%0d got=%h exp=%h", c, en, lw_seq[c]); end
         if (c == 4) begin
            n_checks++;
            if (MemReg !== 1'b1) begin n_fail++; $display("FAIL lw_memreg got=%b exp=1", MemReg); end
         end
         @(negedge clk);
      end
      opcode = 6'd6; mode = 2'b00;
      for (int c = 0; c < 4; c++) begin
         #1;
         n_checks++;
         if (en !== sw_seq[c]) begin n_fail++; $display("FAIL sw_en c=%0d got=%h exp=%h", c, en, sw_seq[c]); end
         n_checks++;
         if (RegSrc !== 1'b1) begin n_fail++; $display("FAIL sw_regsrc c=%0d got=%b exp=1", c, RegSrc); end
         @(negedge clk);
      end
   endtask

   task automatic test_branch;
      logic [5:0] ops [6];
      logic [2:0] flg [6];
      logic       tk  [6];
      ops = '{6'd7, 6'd7, 6'd9, 6'd10, 6'd8, 6'd8};
      flg = '{3'b011, 3'b001, 3'b100, 3'b100, 3'b010, 3'b011};
      tk  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 6; i++) begin
         opcode = ops[i]; {z, n, v} = flg[i];
         for (int c = 0; c < 3; c++) begin
            #1;
            if (c == 1) begin
               n_checks++;
               if (en !== 8'h00) begin n_fail++; $display("FAIL br_decode_en i=%0d got=%h exp=00", i, en); end
            end
            if (c == 2) begin
               n_checks++;
               if (en !== {1'b0, tk[i], 6'b0} || PCsrc !== 2'b11 || ALUop !== 2'b10) begin
                  n_fail++; $display("FAIL br_take i=%0d en=%h pcsrc=%b aluop=%b exp_pcwrite=%b", i, en, PCsrc, ALUop, tk[i]);
               end
            end
            @(negedge clk);
         end
      end
      {z, n, v} = 3'b000;
   endtask

   task automatic test_illegal;
      logic [7:0] seq [4];
      seq = '{8'hC0, 8'h01, 8'hC0, 8'h01};
      opcode = 6'd63;
      for (int c = 0; c < 4; c++) begin
         #1;
         n_checks++;
         if (en !== seq[c]) begin n_fail++; $display("FAIL illegal63 c=%0d got=%h exp=%h", c, en, seq[c]); end
         @(negedge clk);
      end
   endtask

`ifdef STACK_OPS_EN
   task automatic test_stack;
      logic [5:0] ops  [4];
      logic [7:0] en3  [4];
      logic [5:0] sel3 [4];
      ops  = '{6'd12, 6'd13, 6'd14, 6'd15};
      en3  = '{8'h4A, 8'h4C, 8'h0A, 8'h0C};
      // {PCsrc, StackALU, StackSelect, MemWriteSel}
      sel3 = '{6'b00_01_1_1, 6'b10_10_0_0, 6'b00_01_1_0, 6'b00_10_0_0};
      for (int i = 0; i < 4; i++) begin
         opcode = ops[i];
         for (int c = 0; c < ((i == 3) ? 4 : 3); c++) begin
            #1;
            if (c == 2) begin
               n_checks++;
               if (en !== en3[i] || {PCsrc, StackALU, StackSelect, MemWriteSel} !== sel3[i]) begin
                  n_fail++; $display("FAIL stack op=%0d en=%h exp=%h sel=%b exp=%b", ops[i], en, en3[i],
                                     {PCsrc, StackALU, StackSelect, MemWriteSel}, sel3[i]);
               end
            end
            if (c == 3) begin
               n_checks++;
               if (en !== 8'h20 || MemReg !== 1'b1) begin n_fail++; $display("FAIL pop_wb en=%h memreg=%b exp=20/1", en, MemReg); end
            end
            @(negedge clk);
         end
      end
   endtask
`else
   task automatic test_stack;
      logic [7:0] seq [2];
      seq = '{8'hC0, 8'h01};
      for (int op = 12; op < 16; op++) begin
         opcode = 6'(op);
         for (int c = 0; c < 2; c++) begin
            #1;
            n_checks++;
            if (en !== seq[c] || {StackSelect, MemWriteSel, StackALU} !== 4'b0) begin
               n_fail++; $display("FAIL nostack op=%0d c=%0d en=%h exp=%h", op, c, en, seq[c]);
            end
            @(negedge clk);
         end
      end
   endtask
`endif

   task automatic test_reset_mid_exec;
      opcode = 6'd1;
      @(negedge clk);
      @(negedge clk);
      #1;
      n_checks++;
      if (ALUsrcA !== 2'b01) begin n_fail++; $display("FAIL abort_in_exec alusrca=%b exp=01", ALUsrcA); end
      #1 reset = 1'b0;
      #1;
      n_checks++;
      if (en !== 8'h00) begin n_fail++; $display("FAIL abort_en got=%h exp=00", en); end
      @(negedge clk);
      #1;
      n_checks++;
      if (RegWrite !== 1'b0 || en !== 8'h00) begin n_fail++; $display("FAIL abort_regwrite en=%h exp=00", en); end
      @(negedge clk);
      opcode = 6'd11;
      reset = 1'b1;
      #1;
      n_checks++;
      if (IRwrite !== 1'b1 || PCwrite !== 1'b1 || RegWrite !== 1'b0) begin
         n_fail++; $display("FAIL abort_refetch ir=%b pc=%b rw=%b exp=1/1/0", IRwrite, PCwrite, RegWrite);
      end
      repeat (3) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_alu();
      test_load_store();
      test_branch();
      test_illegal();
      test_stack();
      test_reset_mid_exec();
      test_alu();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have no parameters.
REQ-002 SHALL have port: clk  in  1  single clock; all state changes on the rising edge.
REQ-003 SHALL have port: reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: opcode in 6, mode in 2 (IR fields); z, n, v in 1 each (combinational ALU flags).
REQ-005 SHALL have 1-bit outputs: MemWriteSel, MemReg, RegSrc, RegWrite, RegWrite2, IRwrite, PCwrite, StackWrite, sign_ext, StackSelect, mem_read, mem_write, illegal.
REQ-006 SHALL have 2-bit outputs: ALUsrcA, ALUsrcB, PCsrc, ALUop, StackALU.

Function
REQ-007 SHALL use a registered 4-bit state, with outputs decoded combinationally from state and opcode (Moore/opcode-qualified).
REQ-008 SHALL hold every enable at 0 and every select at 0 unless a state lists it.
REQ-009 SHALL use these opcodes: AND 0, ADD 1, SUB 2, ANDI 3, ADDI 4, LW 5, SW 6, BGT 7, BLT 8, BEQ 9, BNE 10, J 11, CALL 12, RET 13, PUSH 14, POP 15.
REQ-010 SHALL use ALUop encoding 00 AND, 01 ADD, 10 SUB.
REQ-011 FETCH(0) SHALL assert IRwrite, PCwrite, ALUsrcA=00, ALUsrcB=10, ALUop=ADD, PCsrc=01, and go to DECODE.
REQ-012 DECODE(1) SHALL set ALUsrcA=00, ALUsrcB=01, ALUop=ADD, sign_ext=1 (branch target to ALUout).
REQ-013 DECODE SHALL dispatch by opcode:
- R/I -> EXEC(2)
- LW/SW -> ADDR(3)
- branches -> BRANCH(6)
- J -> JUMP(7)
- CALL -> CALL(8)
- RET -> RET(9)
- PUSH -> PUSH(10)
- POP -> POP(11)
- other -> FETCH, with illegal=1 for that DECODE cycle
REQ-014 RegSrc SHALL be 1 in every state for SW, BGT..BNE and PUSH.
REQ-015 sign_ext SHALL be 0 for ANDI and 1 otherwise.
REQ-016 EXEC SHALL drive ALUsrcA=01, with ALUsrcB=00 (R) or 01 (I), and ALUop from opcode, then go to WB_ALU(4).
REQ-017 WB_ALU SHALL assert RegWrite with MemReg=0, then go to FETCH.
REQ-018 ADDR SHALL drive ALUsrcA=01, ALUsrcB=01, ALUop=ADD, then go to MEM_RD(5) for LW or MEM_WR(12) for SW.
REQ-019 MEM_RD SHALL assert mem_read with StackALU=00, then go to WB_MEM(13).
REQ-020 WB_MEM SHALL assert RegWrite with MemReg=1, then go to FETCH.
REQ-021 MEM_WR SHALL assert mem_write with StackALU=00 and MemWriteSel=0, then go to FETCH.
REQ-022 For LW/SW with mode=01 (post-increment), RegWrite2 SHALL be asserted in WB_MEM or MEM_WR respectively.
REQ-023 BRANCH SHALL drive ALUsrcA=01, ALUsrcB=00, ALUop=SUB, PCsrc=11, then go to FETCH.
REQ-024 BRANCH SHALL assert PCwrite only when its condition holds:
- BEQ: z
- BNE: !z
- BGT: !z & (n==v)
- BLT: n!=v
REQ-025 JUMP SHALL assert PCwrite with PCsrc=00.
REQ-026 CALL SHALL assert mem_write, MemWriteSel=1, StackALU=01, StackSelect=1, StackWrite, PCwrite with PCsrc=00.
REQ-027 RET SHALL assert mem_read, StackALU=10, PCsrc=10, PCwrite, and StackWrite with StackSelect=0, ALUsrcA=10, ALUsrcB=10, ALUop=ADD.
REQ-028 PUSH SHALL assert mem_write, MemWriteSel=0, StackALU=01, StackSelect=1, StackWrite.
REQ-029 POP SHALL perform RET's memory read and SP increment without PCwrite, then go to WB_MEM.
REQ-030 JUMP, CALL, RET and PUSH SHALL return to FETCH.
REQ-031 Cycle counts (FETCH to next FETCH) SHALL be:
- R/I: 4
- LW: 5
- SW: 4
- branch, J, CALL, RET, PUSH: 3
- POP: 4
- illegal: 2
REQ-032 Unused state codes SHALL go to FETCH with all enables 0.

Reset
REQ-033 reset low SHALL asynchronously force state=FETCH.
REQ-034 While reset is low, every enable output SHALL be 0: IRwrite, PCwrite, RegWrite, RegWrite2, StackWrite, mem_read, mem_write, illegal.
REQ-035 The first FETCH SHALL execute on the first rising clk after reset deasserts.
REQ-036 Reset mid-instruction SHALL abandon it with no further writes.

Configuration
REQ-037 With STACK_OPS_EN defined, CALL/RET/PUSH/POP SHALL be supported.
REQ-038 Without STACK_OPS_EN, opcodes 12-15 SHALL decode as illegal, and StackWrite, StackSelect, MemWriteSel and StackALU SHALL be constant 0.

Verification
REQ-039 Reset low mid-EXEC, release -> next cycle IRwrite=1, PCwrite=1; RegWrite never asserted for the aborted instruction.
REQ-040 ADD (opcode 1) -> enable sequence IRwrite, -, -, RegWrite (4 cycles), with ALUop=01 in EXEC.
REQ-041 LW with mode=01 -> 5 cycles; mem_read in cycle 4; RegWrite and RegWrite2 in cycle 5.
REQ-042 BGT, flags z=0 n=1 v=1 -> PCwrite=1 with PCsrc=11; same with n=0, v=1 -> PCwrite=0.
REQ-043 CALL then RET -> CALL cycle: mem_write=1, StackALU=01, StackWrite=1, PCsrc=00; RET cycle: mem_read=1, PCsrc=10, StackWrite=1.
REQ-044 opcode 63 -> illegal=1 in DECODE, back to FETCH; with STACK_OPS_EN undefined, opcode 14 -> illegal=1 and mem_write stays 0.
